vm_brew_sequencer: RTL and testbench
====================================

// Module: vm_brew_sequencer
// PURPOSE
// Order/brew controller for the coffee vending machine. Accumulates coin credit or NFC payment.
// Checks the water level and bean sensor, then sequences the grinder, heater and pump with fixed cycle counts.
// Reports COFFEE or ERROR and returns change or a refund. Sits between the payment/sensor inputs and the brew actuators.
// PARAMETERS
// PRICE        10  credit units required per cup (C5=5, C10=10)
// WATER_MIN    5   minimum WATER level needed to start a brew
// GRIND_CYC    4   cycles GRIND is held high
// HEAT_CYC     8   cycles HEAT is held high
// POUR_CYC     6   cycles PUMP is held high
// TIMEOUT_CYC  64  idle cycles in PAY before the credit is refunded
// PORTS
// clk         in   1  system clock, rising edge
// rst         in   1  synchronous reset, active-high
// C5          in   1  5-unit coin accepted this cycle (1-cycle pulse)
// C10         in   1  10-unit coin accepted this cycle (1-cycle pulse)
// NFC         in   1  card payment approved this cycle (pays full PRICE)
// WATER       in   5  water tank level
// BEANS       in   1  1 = beans present
// GRIND       out  1  grinder enable
// HEAT        out  1  heater enable
// PUMP        out  1  pump enable
// COFFEE      out  1  cup finished (1-cycle pulse)
// ERROR       out  1  resource fault (1-cycle pulse)
// REFUND      out  5  change/refund amount, valid when REFUND_VLD=1
// REFUND_VLD  out  1  1-cycle pulse: dispense REFUND
// REJECT      out  1  1-cycle pulse: a coin arrived while busy and is returned
// BEHAVIOUR
// - Clock and reset: single clock; reset is synchronous and active-high, sampled on the rising edge of clk.
// - Reset: state=IDLE, credit=0, timer=0, all outputs 0. Reset mid-brew aborts immediately: actuators drop next edge, no refund issued.
// - Credit register: 5 bits, saturating at 31. Each cycle it adds 5*C5 + 10*C10 (both high in one cycle = +15).
// - States and transitions:
//   IDLE:  any C5/C10 -> PAY with credit updated; NFC -> CHECK with the paid flag set.
//   PAY:   credit>=PRICE or NFC -> CHECK. NFC takes priority and the coin credit is kept for refund.
//          TIMEOUT_CYC cycles with no C5/C10 -> REFUND_VLD, REFUND=credit, credit=0, -> IDLE. The timer restarts on every coin.
//   CHECK: 1 cycle. WATER>=WATER_MIN && BEANS -> GRIND; otherwise -> FAULT.
//   GRIND: GRIND=1 for GRIND_CYC cycles. BEANS=0 in any of these cycles -> FAULT next cycle.
//   HEAT:  HEAT=1 for HEAT_CYC cycles.
//   POUR:  PUMP=1 for POUR_CYC cycles. WATER==0 in any of these cycles -> FAULT.
//   DONE:  1 cycle, COFFEE=1.
//          Coin payment: REFUND=credit-PRICE, with REFUND_VLD=1 only if that value is nonzero.
//          NFC payment: REFUND=credit, with REFUND_VLD=1 only if credit is nonzero.
//          Then credit=0 -> IDLE.
//   FAULT: 1 cycle, ERROR=1, REFUND=credit with REFUND_VLD=1 if credit is nonzero (NFC is not refunded here).
//          Actuators are off. Then credit=0 -> IDLE.
// - Actuator outputs are registered and one-hot: at most one of GRIND/HEAT/PUMP is high in any cycle.
// - C5/C10 in CHECK through FAULT: the credit is unchanged and REJECT pulses the next cycle.
//   NFC in these states is ignored.
// - Latency from entering CHECK to COFFEE: 1+GRIND_CYC+HEAT_CYC+POUR_CYC cycles, which is 19 with the defaults.
// - REFUND holds 0 whenever REFUND_VLD=0.
// TESTING
// 1. rst, WATER=0, BEANS=1, C10 pulse -> CHECK fails; ERROR pulses, REFUND=10 with REFUND_VLD; COFFEE stays 0.
// 2. WATER=5, BEANS=0, C5 then C5 -> ERROR pulse, REFUND=10 with REFUND_VLD; GRIND never asserts.
// 3. WATER=5, BEANS=1, C5+C5 -> GRIND 4, HEAT 8, PUMP 6 cycles; COFFEE 19 cycles after CHECK; no REFUND_VLD.
// 4. C10 then C5 (15) -> brew proceeds; DONE has COFFEE=1, REFUND=5, REFUND_VLD=1.
// 5. C5 only, then 64 idle cycles -> REFUND=5 with REFUND_VLD, back to IDLE; a C10 during a brew -> REJECT pulse.
// 6. NFC with WATER=5, BEANS=1; drop BEANS mid-GRIND -> ERROR, no refund. Repeat and assert rst mid-HEAT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/vm_brew_sequencer.sv
// vm_brew_sequencer
// Order/brew controller for the coffee vending machine. Collects coin credit
// or an NFC approval, checks water and beans, then runs grinder, heater and
// pump for fixed cycle counts. Ends with a COFFEE or ERROR pulse and hands
// back change or a refund.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   C5, C10           coin accepted pulses (5 / 10 credit units)
//   NFC               card payment approved pulse (pays the full price)
//   WATER [4:0]       water tank level
//   BEANS             1 = beans present
//   GRIND/HEAT/PUMP   registered, mutually exclusive actuator enables
//   COFFEE, ERROR     1-cycle completion / fault pulses
//   REFUND [4:0]      change/refund amount, nonzero only while REFUND_VLD=1
//   REFUND_VLD        1-cycle pulse: dispense REFUND
//   REJECT            1-cycle pulse: a coin arrived while busy and is returned
module vm_brew_sequencer #(
  parameter int PRICE       = 10,
  parameter int WATER_MIN   = 5,
  parameter int GRIND_CYC   = 4,
  parameter int HEAT_CYC    = 8,
  parameter int POUR_CYC    = 6,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       C5,
  input  logic       C10,
  input  logic       NFC,
  input  logic [4:0] WATER,
  input  logic       BEANS,
  output logic       GRIND,
  output logic       HEAT,
  output logic       PUMP,
  output logic       COFFEE,
  output logic       ERROR,
  output logic [4:0] REFUND,
  output logic       REFUND_VLD,
  output logic       REJECT
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int CW = 8;
  localparam logic [4:0] PRICE_V     = 5'(PRICE);
  localparam logic [4:0] WATER_MIN_V = 5'(WATER_MIN);

  typedef enum logic [2:0] {
    S_IDLE, S_PAY, S_CHECK, S_GRIND, S_HEAT, S_POUR, S_DONE, S_FAULT
  } state_t;

  state_t          state, state_nxt;
  logic [4:0]      credit, credit_nxt, credit_sum, coin_val;
  logic [TW-1:0]   timer, timer_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            nfc_paid, nfc_nxt;
  logic            coin, timeout;
  logic            grind_d, heat_d, pump_d, coffee_d, error_d, vld_d, reject_d;
  logic [4:0]      refund_d;

  // Credit never wraps: anything past 31 sticks at 31.
  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  assign coin       = C5 | C10;
  assign coin_val   = (C5 ? 5'd5 : 5'd0) + (C10 ? 5'd10 : 5'd0);
  assign credit_sum = sat_add(credit, coin_val);

  // State register; outputs are registered alongside so they line up with
  // the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      credit     <= '0;
      timer      <= '0;
      cnt        <= '0;
      nfc_paid   <= 1'b0;
      GRIND      <= 1'b0;
      HEAT       <= 1'b0;
      PUMP       <= 1'b0;
      COFFEE     <= 1'b0;
      ERROR      <= 1'b0;
      REFUND     <= '0;
      REFUND_VLD <= 1'b0;
      REJECT     <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit     <= credit_nxt;
      timer      <= timer_nxt;
      cnt        <= cnt_nxt;
      nfc_paid   <= nfc_nxt;
      GRIND      <= grind_d;
      HEAT       <= heat_d;
      PUMP       <= pump_d;
      COFFEE     <= coffee_d;
      ERROR      <= error_d;
      REFUND     <= refund_d;
      REFUND_VLD <= vld_d;
      REJECT     <= reject_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    timer_nxt  = timer;
    cnt_nxt    = cnt;
    nfc_nxt    = nfc_paid;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        timer_nxt = '0;
        cnt_nxt   = '0;
        if (NFC) begin
          // Coins in the same cycle are banked and come back as change.
          credit_nxt = credit_sum;
          nfc_nxt    = 1'b1;
          state_nxt  = S_CHECK;
        end else if (coin) begin
          credit_nxt = credit_sum;
          state_nxt  = S_PAY;
        end
      end
      S_PAY: begin
        credit_nxt = credit_sum;
        if (NFC) begin
          nfc_nxt   = 1'b1;
          state_nxt = S_CHECK;
        end else if (credit_sum >= PRICE_V) begin
          state_nxt = S_CHECK;
        end else if (coin) begin
          timer_nxt = '0;
        end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
          timeout    = 1'b1;
          credit_nxt = '0;
          timer_nxt  = '0;
          state_nxt  = S_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_CHECK: begin
        cnt_nxt   = '0;
        state_nxt = (WATER >= WATER_MIN_V && BEANS) ? S_GRIND : S_FAULT;
      end
      S_GRIND: begin
        if (!BEANS) begin
          state_nxt = S_FAULT;
        end else if (cnt == CW'(GRIND_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_HEAT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HEAT: begin
        if (cnt == CW'(HEAT_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_POUR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_POUR: begin
        if (WATER == 5'd0) begin
          state_nxt = S_FAULT;
        end else if (cnt == CW'(POUR_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin // S_DONE, S_FAULT
        credit_nxt = '0;
        nfc_nxt    = 1'b0;
        state_nxt  = S_IDLE;
      end
    endcase
  end

  // Output logic: values to be registered for the coming cycle.
  always_comb begin
    grind_d  = (state_nxt == S_GRIND);
    heat_d   = (state_nxt == S_HEAT);
    pump_d   = (state_nxt == S_POUR);
    coffee_d = (state_nxt == S_DONE);
    error_d  = (state_nxt == S_FAULT);
    refund_d = '0;
    vld_d    = 1'b0;
    reject_d = coin && (state inside {S_CHECK, S_GRIND, S_HEAT, S_POUR, S_DONE, S_FAULT});
    if (timeout) begin
      refund_d = credit;
      vld_d    = 1'b1;
    end else if (state_nxt == S_DONE) begin
      // Card buyers get all coin credit back; coin buyers get the excess.
      refund_d = nfc_paid ? credit : credit - PRICE_V;
      vld_d    = (refund_d != 5'd0);
    end else if (state_nxt == S_FAULT) begin
      refund_d = credit;
      vld_d    = (credit != 5'd0);
    end
  end

endmodule

// File: tb/tb_vm_brew_sequencer.sv
module tb_vm_brew_sequencer;

  localparam int PRICE = 10, WMIN = 5, G = 4, H = 8, P = 6, TMO = 64;
  localparam int LAT = 1 + G + H + P;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       C5 = 1'b0, C10 = 1'b0, NFC = 1'b0;
  logic [4:0] WATER = 5'd0;
  logic       BEANS = 1'b1;
  logic       GRIND, HEAT, PUMP, COFFEE, ERROR, REFUND_VLD, REJECT;
  logic [4:0] REFUND;

  vm_brew_sequencer dut (
    .clk(clk), .rst(rst), .C5(C5), .C10(C10), .NFC(NFC), .WATER(WATER), .BEANS(BEANS),
    .GRIND(GRIND), .HEAT(HEAT), .PUMP(PUMP), .COFFEE(COFFEE), .ERROR(ERROR),
    .REFUND(REFUND), .REFUND_VLD(REFUND_VLD), .REJECT(REJECT)
  );

  always #5 clk = ~clk;

  wire [11:0] outs = {GRIND, HEAT, PUMP, COFFEE, ERROR, REFUND_VLD, REJECT, REFUND};

  int n_cmp = 0;
  int n_err = 0;
  bit chk_model = 1'b0;

  function automatic logic [11:0] mk(input bit g, h, p, c, e, v, r, input int rf);
    return {g, h, p, c, e, v, r, 5'(rf)};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h (g h p c e v r refund)", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: transaction phases, with the brew tracked as elapsed
  // cycles since CHECK and mapped onto the grind/heat/pour windows.
  int m_mode = 0; // 0 idle, 1 paying, 2 brewing, 3 fault cycle
  int m_credit = 0, m_idle = 0, m_e = 0;
  bit m_nfc = 1'b0;
  logic [11:0] m_exp = '0;

  function automatic int min31(input int v);
    return (v > 31) ? 31 : v;
  endfunction

  task automatic model_step(input bit r, c5, c10, nfc, input int water, input bit beans);
    bit g = 0, h = 0, p = 0, cf = 0, er = 0, v = 0, rj = 0, coin, fault;
    int rf = 0;
    int cv;
    cv = 5 * int'(c5) + 10 * int'(c10);
    coin = c5 | c10;
    if (r) begin
      m_mode = 0; m_credit = 0; m_idle = 0; m_e = 0; m_nfc = 0;
    end else begin
      case (m_mode)
        0: begin
          if (nfc) begin
            m_credit = min31(m_credit + cv); m_nfc = 1; m_mode = 2; m_e = 0;
          end else if (coin) begin
            m_credit = min31(m_credit + cv); m_mode = 1; m_idle = 0;
          end
        end
        1: begin
          m_credit = min31(m_credit + cv);
          if (nfc) begin
            m_nfc = 1; m_mode = 2; m_e = 0;
          end else if (m_credit >= PRICE) begin
            m_mode = 2; m_e = 0;
          end else if (coin) begin
            m_idle = 0;
          end else begin
            m_idle++;
            if (m_idle == TMO) begin
              v = 1; rf = m_credit; m_credit = 0; m_mode = 0;
            end
          end
        end
        2: begin
          rj = coin;
          fault = (m_e == 0 && !(water >= WMIN && beans)) ||
                  (m_e >= 1 && m_e <= G && !beans) ||
                  (m_e >= G + H + 1 && m_e <= G + H + P && water == 0);
          if (fault) begin
            m_mode = 3; er = 1;
            if (m_credit != 0) begin v = 1; rf = m_credit; end
          end else if (m_e == LAT) begin
            m_mode = 0; m_credit = 0; m_nfc = 0;
          end else begin
            m_e++;
            g = (m_e >= 1 && m_e <= G);
            h = (m_e >= G + 1 && m_e <= G + H);
            p = (m_e >= G + H + 1 && m_e <= G + H + P);
            if (m_e == LAT) begin
              cf = 1;
              rf = m_nfc ? m_credit : m_credit - PRICE;
              v = (rf != 0);
            end
          end
        end
        default: begin
          rj = coin; m_credit = 0; m_nfc = 0; m_mode = 0;
        end
      endcase
    end
    m_exp = mk(g, h, p, cf, er, v, rj, rf);
  endtask

  task automatic step(input bit c5_i, c10_i, nfc_i);
    C5 = c5_i; C10 = c10_i; NFC = nfc_i;
    @(posedge clk);
    model_step(rst, C5, C10, NFC, int'(WATER), BEANS);
    #1;
    if (chk_model) check("model", outs, m_exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit rst, c5, c10, nfc;
    logic [4:0] water;
    bit beans;
    logic [11:0] exp;
  } vec_t;

  vec_t tv[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ng, nh, np, coffee_at, nvld, nonehot, got, rf, at, seen;
    int coin_div;

    tv[0] = '{1, 0, 0, 0, 5'd0, 1, mk(0,0,0,0,0,0,0,0)};
    tv[1] = '{0, 0, 1, 0, 5'd0, 1, mk(0,0,0,0,0,0,0,0)};
    tv[2] = '{0, 0, 0, 0, 5'd0, 1, mk(0,0,0,0,0,0,0,0)};
    tv[3] = '{0, 0, 0, 0, 5'd0, 1, mk(0,0,0,0,1,1,0,10)};
    tv[4] = '{0, 1, 0, 0, 5'd0, 1, mk(0,0,0,0,0,0,1,0)};
    tv[5] = '{0, 0, 0, 0, 5'd5, 0, mk(0,0,0,0,0,0,0,0)};
    tv[6] = '{0, 1, 0, 0, 5'd5, 0, mk(0,0,0,0,0,0,0,0)};
    tv[7] = '{0, 1, 0, 0, 5'd5, 0, mk(0,0,0,0,0,0,0,0)};
    tv[8] = '{0, 0, 0, 0, 5'd5, 0, mk(0,0,0,0,1,1,0,10)};
    tv[9] = '{0, 0, 0, 0, 5'd5, 0, mk(0,0,0,0,0,0,0,0)};

    for (int i = 0; i < 10; i++) begin
      rst = tv[i].rst; WATER = tv[i].water; BEANS = tv[i].beans;
      step(tv[i].c5, tv[i].c10, tv[i].nfc);
      check($sformatf("vec%0d", i), outs, tv[i].exp);
    end
    rst = 1'b0;

    // Full coin brew at exact price
    WATER = 5'd5; BEANS = 1'b1;
    do_reset();
    step(1, 0, 0); step(1, 0, 0);
    ng = 0; nh = 0; np = 0; coffee_at = 0; nvld = 0; nonehot = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0);
      ng += int'(GRIND); nh += int'(HEAT); np += int'(PUMP);
      if (COFFEE && coffee_at == 0) coffee_at = k;
      if (int'(GRIND) + int'(HEAT) + int'(PUMP) > 1) nonehot++;
      if (REFUND_VLD) nvld++;
    end
    check_int("s3_grind_cycles", ng, G);
    check_int("s3_heat_cycles", nh, H);
    check_int("s3_pump_cycles", np, P);
    check_int("s3_coffee_latency", coffee_at, LAT);
    check_int("s3_refund_vld", nvld, 0);
    check_int("s3_onehot", nonehot, 0);

    // Overpay gives change at DONE
    do_reset();
    step(0, 1, 0); step(1, 0, 0);
    got = 0; rf = 0; at = 0;
    for (int k = 1; k <= 40; k++) begin
      step(0, 0, 0);
      if (COFFEE) begin got = 1; rf = int'(REFUND); at = int'(REFUND_VLD); break; end
    end
    check_int("s4_coffee", got, 1);
    check_int("s4_refund", rf, 5);
    check_int("s4_refund_vld", at, 1);
    step(0, 0, 0);

    // Payment timeout, then a coin during a brew
    do_reset();
    step(1, 0, 0);
    at = 0; rf = 0;
    for (int k = 1; k <= 100; k++) begin
      step(0, 0, 0);
      if (REFUND_VLD) begin at = k; rf = int'(REFUND); break; end
    end
    check_int("s5_timeout_cycles", at, TMO);
    check_int("s5_timeout_refund", rf, 5);
    step(0, 0, 1); step(0, 0, 0);
    step(0, 1, 0);
    check_int("s5_reject", int'(REJECT), 1);
    step(0, 0, 0);
    check_int("s5_reject_pulse", int'(REJECT), 0);
    got = 0; nvld = 0;
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 0);
      if (COFFEE) got++;
      if (REFUND_VLD) nvld++;
    end
    check_int("s5_brew_done", got, 1);
    check_int("s5_no_refund", nvld, 0);

    // NFC brew: beans vanish mid-grind, then reset mid-heat
    do_reset();
    step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
    BEANS = 1'b0;
    step(0, 0, 0);
    check("s6_fault", outs, mk(0,0,0,0,1,0,0,0));
    BEANS = 1'b1;
    step(0, 0, 0);
    check("s6_after_fault", outs, mk(0,0,0,0,0,0,0,0));
    step(0, 0, 1);
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      step(0, 0, 0);
      if (HEAT) begin seen = 1; break; end
    end
    check_int("s6_heat_reached", seen, 1);
    step(0, 0, 0);
    rst = 1'b1;
    step(0, 0, 0);
    check("s6_reset_mid_heat", outs, mk(0,0,0,0,0,0,0,0));
    rst = 1'b0;
    step(0, 0, 0);
    check("s6_after_reset", outs, mk(0,0,0,0,0,0,0,0));

    // Randomized run against the reference model
    do_reset();
    chk_model = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      bit c5r, c10r, nfcr;
      coin_div = ((i / 500) % 2 == 0) ? 8 : 150;
      rst   = ($urandom % 300 == 0);
      c5r   = ($urandom % coin_div == 0);
      c10r  = ($urandom % coin_div == 0);
      nfcr  = ($urandom % 90 == 0);
      WATER = ($urandom % 12 == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom_range(5, 31));
      BEANS = ($urandom % 30 != 0);
      step(c5r, c10r, nfcr);
    end
    chk_model = 1'b0;
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
